// File: rtl/lc3b_types.sv
// Shared LC-3b types: machine word and fetch-unit state encoding.
`default_nettype none

package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DELIVER = 2'd2,
    SQUASH  = 2'd3
  } lc3b_fetch_state;

endpackage

`default_nettype wire

// File: rtl/pc_plus2.sv
// PC incrementer: returns the next sequential instruction address (wraps at 16 bits).
`default_nettype none

module pc_plus2
  import lc3b_types::*;
(
  input  lc3b_word pc_i,
  output lc3b_word pc_o
);

  assign pc_o = pc_i + 16'd2;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one read at the PC, buffers the word for decode,
// and handles redirects that arrive while a read is outstanding.
`default_nettype none

module fetch_unit
  import lc3b_types::*;
#(
  parameter lc3b_word PC_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        pc_load,
  input  logic [15:0] pc_in,
  input  logic [15:0] mem_rdata,
  input  logic        mem_resp,
  input  logic        decode_ready,
  output logic        mem_read,
  output logic [15:0] mem_address,
  output logic [15:0] ir_word,
  output logic        ir_load,
  output logic [15:0] pc_out
);

  lc3b_fetch_state state_q, state_d;
  lc3b_word        pc_q, pc_d;
  lc3b_word        addr_q, addr_d;
  lc3b_word        ir_q, ir_d;
  lc3b_word        pc_inc;
  lc3b_word        pc_redirect;

  pc_plus2 u_pc_plus2 (
    .pc_i (pc_q),
    .pc_o (pc_inc)
  );

  // Instructions are halfword aligned; bit 0 of a redirect target is dropped.
  assign pc_redirect = pc_in & 16'hFFFE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= PC_RESET;
      addr_q  <= 16'h0000;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_load ? pc_redirect : pc_q;
    addr_d   = addr_q;
    ir_d     = ir_q;
    mem_read = 1'b0;
    ir_load  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fetch_en) begin
          addr_d  = pc_q;
          state_d = REQ;
        end
      end
      REQ: begin
        mem_read = 1'b1;
        if (mem_resp && pc_load) begin
          state_d = IDLE;
        end else if (pc_load) begin
          // The read cannot be cancelled; wait it out and drop the data.
          state_d = SQUASH;
        end else if (mem_resp) begin
          ir_d    = mem_rdata;
          pc_d    = pc_inc;
          state_d = DELIVER;
        end
      end
      DELIVER: begin
        if (pc_load) begin
          state_d = IDLE;
        end else if (decode_ready) begin
          ir_load = 1'b1;
          state_d = IDLE;
        end
      end
      SQUASH: begin
        mem_read = 1'b1;
        if (mem_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_address = addr_q;
  assign ir_word     = ir_q;
  assign pc_out      = pc_q;

endmodule

`default_nettype wire
